// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU command driver: FSM state encoding,
// default ALU port widths and the packed command layout held in the FIFO.
package alu_drv_pkg;

    localparam int ALU_DW  = 4;
    localparam int ALU_OPW = 4;
    localparam int ALU_RW  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESPOND = 2'd2
    } drv_state_e;

    // FIFO entries are stored as {op, b, a}, matching this field order
    typedef struct packed {
        logic [ALU_OPW-1:0] op;
        logic [ALU_DW-1:0]  b;
        logic [ALU_DW-1:0]  a;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered pointers and an occupancy count.
// The head entry is read combinationally; a push is only visible on the next edge.
module alu_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Host-side initiator for the 4-bit ALU: queues commands, drives the ALU pins,
// waits a fixed settle time, captures the result and returns it in order.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int OPW           = ALU_OPW,
    parameter int DW            = ALU_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [DW-1:0]   cmd_a,
    input  logic [DW-1:0]   cmd_b,
    input  logic [OPW-1:0]  cmd_op,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [2*DW-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_result,
    output logic [OPW-1:0]  rsp_op,
    output logic            busy
);

    localparam int CW = OPW + 2*DW;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    drv_state_e       state;
    logic [SW-1:0]    settle_cnt;
    logic [CW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic             pop;

    alu_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_b, cmd_a}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    // ALU pins change only on a pop, so they stay glitch-free through SETTLE and RESPOND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        {alu_op, alu_b, alu_a} <= head;
                        settle_cnt             <= SW'(SETTLE_CYCLES - 1);
                        state                  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_op     <= alu_op;
                        rsp_valid  <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver: two instances (settle 2 and settle 1)
// in front of a behavioural ALU, with directed commands and hand-computed results.
module tb_alu_cmd_driver;

    typedef struct {
        logic [7:0] res;
        logic [3:0] op;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [3:0] cmd_a, cmd_b, cmd_op, alu_a, alu_b, alu_op, rsp_op;
    logic [7:0] alu_result, rsp_result;

    logic       s1_cmd_valid, s1_cmd_ready, s1_rsp_valid, s1_rsp_ready, s1_busy;
    logic [3:0] s1_cmd_a, s1_cmd_b, s1_cmd_op, s1_alu_a, s1_alu_b, s1_alu_op, s1_rsp_op;
    logic [7:0] s1_alu_result, s1_rsp_result;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    exp_t exp_q1[$];
    int   hs_cyc[$];
    int   hs_cyc1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_driver #(.DEPTH(4), .SETTLE_CYCLES(2), .OPW(4), .DW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .busy(busy)
    );

    alu_cmd_driver #(.DEPTH(4), .SETTLE_CYCLES(1), .OPW(4), .DW(4)) dut_s1 (
        .clk(clk), .rst(rst),
        .cmd_valid(s1_cmd_valid), .cmd_ready(s1_cmd_ready),
        .cmd_a(s1_cmd_a), .cmd_b(s1_cmd_b), .cmd_op(s1_cmd_op),
        .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_op(s1_alu_op), .alu_result(s1_alu_result),
        .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready),
        .rsp_result(s1_rsp_result), .rsp_op(s1_rsp_op), .busy(s1_busy)
    );

    // Behavioural ALU: 0 add, 1 subtract (8-bit wrap), 2 and, 3 multiply
    function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [7:0] wa, wb;
        wa = {4'b0, a};
        wb = {4'b0, b};
        case (op)
            4'd0:    return wa + wb;
            4'd1:    return wa - wb;
            4'd2:    return wa & wb;
            4'd3:    return wa * wb;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result    = aluModel(alu_a, alu_b, alu_op);
    always_comb s1_alu_result = aluModel(s1_alu_a, s1_alu_b, s1_alu_op);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitors compare on every response handshake seen half a cycle before the edge
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL rsp_unexpected: got result %0h op %0h, required no response", rsp_result, rsp_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_result", 32'(rsp_result), 32'(e.res));
                checkOutput("rsp_op", 32'(rsp_op), 32'(e.op));
                hs_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s1_rsp_valid && s1_rsp_ready) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL s1_rsp_unexpected: got result %0h op %0h, required no response", s1_rsp_result, s1_rsp_op);
            end else begin
                exp_t e;
                e = exp_q1.pop_front();
                checkOutput("s1_rsp_result", 32'(s1_rsp_result), 32'(e.res));
                checkOutput("s1_rsp_op", 32'(s1_rsp_op), 32'(e.op));
                hs_cyc1.push_back(cyc);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers one command; returns just after the accepting edge (cyc == accept edge)
    task automatic applyStimulus(input bit second, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] op, input logic [7:0] res, input bit expect_rsp);
        int   waited = 0;
        exp_t e;
        e.res = res;
        e.op  = op;
        if (second) begin
            s1_cmd_valid = 1'b1; s1_cmd_a = a; s1_cmd_b = b; s1_cmd_op = op;
        end else begin
            cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        end
        while (!(second ? s1_cmd_ready : cmd_ready) && waited < 100) begin
            nextCycle();
            waited++;
        end
        if (!(second ? s1_cmd_ready : cmd_ready)) begin
            n_checks++;
            $display("[TB] FAIL cmd_accept_timeout: got cmd_ready low for %0d cycles, required acceptance", waited);
        end else if (expect_rsp) begin
            if (second) exp_q1.push_back(e);
            else        exp_q.push_back(e);
        end
        nextCycle();
        cmd_valid    = 1'b0;
        s1_cmd_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || exp_q1.size() != 0 || busy || s1_busy) && n < 200) begin
            nextCycle();
            n++;
        end
        checkOutput("drain_pending", 32'(exp_q.size() + exp_q1.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted;
        exp_t e;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
        s1_cmd_valid = 1'b0; s1_cmd_a = '0; s1_cmd_b = '0; s1_cmd_op = '0; s1_rsp_ready = 1'b1;
        repeat (3) nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("[TB] reset state");
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        checkOutput("reset_rsp_data", 32'({rsp_result, rsp_op}), 32'd0);

        $display("[TB] reset during SETTLE");
        applyStimulus(1'b0, 4'd7, 4'd2, 4'd0, 8'h09, 1'b0);
        nextCycle();
        checkOutput("t1_pre_busy", 32'(busy), 32'd1);
        checkOutput("t1_pre_alu_a", 32'(alu_a), 32'd7);
        rst = 1'b1;
        #1;
        checkOutput("t1_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t1_rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        checkOutput("t1_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("t1_rst_busy", 32'(busy), 32'd0);
        nextCycle();
        rst = 1'b0;
        repeat (6) nextCycle();
        checkOutput("t1_post_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t1_post_busy", 32'(busy), 32'd0);

        $display("[TB] single command latency");
        applyStimulus(1'b0, 4'd3, 4'd5, 4'd0, 8'h08, 1'b1);
        nextCycle();
        checkOutput("t2_alu_pins", 32'({alu_a, alu_b, alu_op}), 32'h350);
        checkOutput("t2_valid_t1", 32'(rsp_valid), 32'd0);
        nextCycle();
        checkOutput("t2_valid_t2", 32'(rsp_valid), 32'd0);
        nextCycle();
        checkOutput("t2_valid_t3", 32'(rsp_valid), 32'd1);
        waitDrain();

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd9, 4'd4, 4'd1, 8'h05, 1'b1);
        applyStimulus(1'b0, 4'd2, 4'd6, 4'd2, 8'h02, 1'b1);
        for (int i = 0; i < 20 && !rsp_valid; i++) nextCycle();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t3_hold", 32'({rsp_valid, rsp_result, rsp_op, alu_a, alu_b, alu_op}),
                        32'({1'b1, 8'h05, 4'h1, 4'h9, 4'h4, 4'h1}));
            nextCycle();
        end
        rsp_ready = 1'b1;
        nextCycle();
        checkOutput("t3_after_hs_alu_a", 32'(alu_a), 32'd9);
        checkOutput("t3_after_hs_valid", 32'(rsp_valid), 32'd0);
        nextCycle();
        checkOutput("t3_second_alu_pins", 32'({alu_a, alu_b, alu_op}), 32'h262);
        waitDrain();

        $display("[TB] full fifo");
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin cmd_a = 4'd1;  cmd_b = 4'd2;  cmd_op = 4'd0; e.res = 8'h03; end
                1: begin cmd_a = 4'd7;  cmd_b = 4'd3;  cmd_op = 4'd1; e.res = 8'h04; end
                2: begin cmd_a = 4'd12; cmd_b = 4'd10; cmd_op = 4'd2; e.res = 8'h08; end
                3: begin cmd_a = 4'd5;  cmd_b = 4'd6;  cmd_op = 4'd3; e.res = 8'h1E; end
                4: begin cmd_a = 4'd15; cmd_b = 4'd14; cmd_op = 4'd0; e.res = 8'h1D; end
                default: begin cmd_a = 4'd4; cmd_b = 4'd4; cmd_op = 4'd3; e.res = 8'h10; end
            endcase
            e.op      = cmd_op;
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                accepted++;
                exp_q.push_back(e);
            end
            nextCycle();
        end
        cmd_valid = 1'b0;
        checkOutput("t4_accepted", 32'(accepted), 32'd5);
        checkOutput("t4_ready_full", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 20 && !rsp_valid; i++) nextCycle();
        repeat (3) nextCycle();
        checkOutput("t4_ready_stall", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;
        checkOutput("t4_ready_after_hs", 32'(cmd_ready), 32'd0);
        nextCycle();
        checkOutput("t4_ready_after_pop", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        waitDrain();

        $display("[TB] ordering and throughput");
        hs_cyc.delete();
        applyStimulus(1'b0, 4'd6,  4'd9,  4'd0, 8'h0F, 1'b1);
        applyStimulus(1'b0, 4'd2,  4'd5,  4'd1, 8'hFD, 1'b1);
        applyStimulus(1'b0, 4'd15, 4'd6,  4'd2, 8'h06, 1'b1);
        applyStimulus(1'b0, 4'd11, 4'd13, 4'd3, 8'h8F, 1'b1);
        waitDrain();
        checkOutput("t5_rsp_count", 32'(hs_cyc.size()), 32'd4);
        for (int i = 1; i < 4; i++) begin
            checkOutput("t5_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd4);
        end

        $display("[TB] settle of one cycle");
        applyStimulus(1'b1, 4'd9, 4'd7, 4'd3, 8'h3F, 1'b1);
        nextCycle();
        checkOutput("t6_alu_pins", 32'({s1_alu_a, s1_alu_b, s1_alu_op}), 32'h973);
        checkOutput("t6_valid_t1", 32'(s1_rsp_valid), 32'd0);
        nextCycle();
        checkOutput("t6_valid_t2", 32'(s1_rsp_valid), 32'd1);
        waitDrain();
        hs_cyc1.delete();
        applyStimulus(1'b1, 4'd8,  4'd8, 4'd0, 8'h10, 1'b1);
        applyStimulus(1'b1, 4'd3,  4'd1, 4'd1, 8'h02, 1'b1);
        applyStimulus(1'b1, 4'd14, 4'd7, 4'd2, 8'h06, 1'b1);
        waitDrain();
        checkOutput("t6_rsp_count", 32'(hs_cyc1.size()), 32'd3);
        for (int i = 1; i < 3; i++) begin
            checkOutput("t6_spacing", 32'(hs_cyc1[i] - hs_cyc1[i-1]), 32'd3);
        end

        repeat (3) nextCycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Host-side initiator for the 4-bit ALU user project: the block that drives the ALU operand/opcode pins and collects its result.
- Accepts commands {a, b, opcode} on a valid/ready stream and queues them in a small FIFO.
- Drives each command onto the ALU inputs, waits a fixed settle time, then captures the 8-bit result.
- Returns each result in command order on a valid/ready response stream.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, >= 2.
- SETTLE_CYCLES, 2: cycles the ALU inputs are held before capture; >= 1.
- OPW, 4: opcode width.
- DW, 4: operand width. The result width is 2*DW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted
- cmd_a  in  DW  operand a
- cmd_b  in  DW  operand b
- cmd_op  in  OPW  ALU opcode
- alu_a  out  DW  to ALU ui_in[3:0]
- alu_b  out  DW  to ALU ui_in[7:4]
- alu_op  out  OPW  to ALU uio_in[3:0]
- alu_result  in  2*DW  from ALU uo_out
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  2*DW  captured ALU result
- rsp_op  out  OPW  opcode that produced rsp_result
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - alu_a, alu_b, alu_op, rsp_result, rsp_op: 0.
  - rsp_valid: 0.
  - FIFO: emptied.
  - FSM: IDLE.
  - cmd_ready: 1 (it is a function of FIFO count).
  - busy: 0.
- Reset mid-operation aborts any in-flight command; queued commands are discarded.
- Command accept: occurs at the edge where cmd_valid && cmd_ready.
  - cmd_ready = (count != DEPTH), combinational from count only. A pop in the same cycle does not raise it.
  - There is no bypass: a command pushed at edge t is first poppable at edge t+1.
  - Simultaneous push and pop keeps count unchanged.
- FSM states: IDLE, SETTLE, RESPOND.
  - IDLE: if count != 0, at the edge pop the head, register alu_a/alu_b/alu_op, load settle counter with SETTLE_CYCLES-1, go to SETTLE. Otherwise stay.
  - SETTLE: counter decrements each edge. At the edge where counter == 0: rsp_result <= alu_result, rsp_op <= alu_op, rsp_valid <= 1, go to RESPOND.
  - RESPOND: hold rsp_* stable. At the edge with rsp_ready high: rsp_valid <= 0, go to IDLE.
- alu_a/alu_b/alu_op hold their last driven values until the next pop. They never glitch during SETTLE or RESPOND.
- Latency from accept at edge t into an empty idle block:
  - ALU inputs are valid after edge t+1.
  - Result is captured at edge t+1+SETTLE_CYCLES.
  - rsp_valid is visible in the following cycle.
- Throughput with rsp_ready tied high: one response every SETTLE_CYCLES+2 cycles.
- Responses are strictly in command order. No data is reordered or dropped.
- Backpressure: rsp_ready low stalls the FSM in RESPOND; the FIFO continues accepting until full.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.
- busy = (state != IDLE) || (count != 0).

Decomposition:
- Package alu_drv_pkg holds:
  - typedef of the state enum (IDLE, SETTLE, RESPOND);
  - constants ALU_DW = 4, ALU_OPW = 4, ALU_RW = 8;
  - a packed command struct {op, b, a}.
- Sub-module alu_cmd_fifo: synchronous FIFO of width OPW+2*DW, parameterised on DEPTH, exposing full/empty/count.
- The top level is the FSM plus capture registers.

Test Plan:
1. Reset in SETTLE: rst pulsed during SETTLE -> asynchronously rsp_valid=0, alu_a/b/op=0, cmd_ready=1, busy=0; no response appears afterwards.
2. Single command, SETTLE_CYCLES=2, ALU model opcode 0 = add, a=3, b=5, accepted at edge 0 -> alu_a=3, alu_b=5, alu_op=0 after edge 1; rsp_valid after edge 3 with rsp_result=8'h08, rsp_op=0.
3. Backpressure: rsp_ready=0 for 10 cycles with a second command queued -> rsp_valid held, rsp_result stable, alu_* unchanged; the second command is driven only after the handshake.
4. Full FIFO, DEPTH=4, rsp_ready=0: 6 back-to-back commands -> exactly 5 accepted (one popped at edge 1); cmd_ready low until the first response is consumed and the next pop occurs.
5. Ordering, rsp_ready=1: 4 commands with ops 0,1,2,3 and distinct operands -> 4 responses in issue order, rsp_op 0..3, spaced 4 cycles apart, results matching the ALU model.
6. Parameter SETTLE_CYCLES=1: a single command accepted at edge 0 -> capture at edge 2; result matches the model; throughput is one response per 3 cycles.
